// File: rtl/a0_trace_fifo.sv
// a0_trace_fifo: captures every change of the CPU a0 result into a show-ahead
// FIFO drained over valid/ready. Pushes that arrive while the FIFO is full are
// dropped, and the drops are tracked by a sticky flag and a saturating counter.
//
// Occupancy model:
//   wptr/rptr carry one extra MSB so that "empty" (wptr == rptr) and
//   "full" (wptr - rptr == DEPTH) are distinguished without a separate flag.
//   All status outputs are decoded from the registered pointers only, so
//   out_ready never reaches out_valid combinationally.
module a0_trace_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [DATA_WIDTH-1:0]      a0_in,
    input  logic                       clr_ovf,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [DATA_WIDTH-1:0] prev_a0;
    logic                  first;

    logic                  push_req;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;
    logic                  cnt_sat;

    // Change detector: the first enabled sample after reset always pushes.
    always_comb begin
        push_req = 1'b0;
        if (en) begin
            push_req = first | (a0_in != prev_a0);
        end
    end

    // Status decode from registered pointers, plus push/pop/drop qualification.
    // A push into a full FIFO is accepted when the head is popped the same
    // cycle; the write then lands in the slot being vacated.
    always_comb begin
        level     = wptr - rptr;
        full      = (level == PW'(DEPTH));
        out_valid = (wptr != rptr);
        pop       = out_valid & out_ready;
        push_ok   = push_req & (~full | pop);
        drop      = push_req & full & ~pop;
        cnt_sat   = (drop_count == {CNT_WIDTH{1'b1}});
    end

    // Head is presented combinationally; masked to zero when empty so the
    // output is deterministic out of reset even though the array is not reset.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = mem[rptr[AW-1:0]];
        end
    end

    // Sample history for change detection; held while capture is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_a0 <= '0;
            first   <= 1'b1;
        end else if (en) begin
            prev_a0 <= a0_in;
            first   <= 1'b0;
        end
    end

    // Pointer advance for accepted pushes and pops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage array; contents are only meaningful between rptr and wptr.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= a0_in;
        end
    end

    // Drop tracking; a drop in the same cycle as a clear restarts the count at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_count <= CNT_WIDTH'(1);
            end else if (!cnt_sat) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (clr_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Directed bench for a0_trace_fifo. A second, tiny instance (DEPTH=2,
// CNT_WIDTH=2) exercises drop-counter saturation in a few cycles.
module tb_a0_trace_fifo;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          en;
    logic [DW-1:0] a0_in;
    logic          clr_ovf;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    level;
    logic          full;
    logic          overflow;
    logic [15:0]   drop_count;

    logic          en2;
    logic [DW-1:0] a0_2;
    logic          clr2;
    logic [DW-1:0] out_data2;
    logic          out_valid2;
    logic          ready2;
    logic [1:0]    level2;
    logic          full2;
    logic          overflow2;
    logic [1:0]    drop_count2;

    int n_vec;
    int n_err;
    logic [DW-1:0] got_q[$];

    a0_trace_fifo #(.DATA_WIDTH(DW), .DEPTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .a0_in(a0_in), .clr_ovf(clr_ovf),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .full(full), .overflow(overflow), .drop_count(drop_count)
    );

    a0_trace_fifo #(.DATA_WIDTH(DW), .DEPTH(2), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .en(en2), .a0_in(a0_2), .clr_ovf(clr2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(ready2),
        .level(level2), .full(full2), .overflow(overflow2), .drop_count(drop_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock: record a pop if one happens at this edge, then settle #1.
    task automatic cycle();
        logic          popped;
        logic [DW-1:0] d;
        popped = out_valid && out_ready;
        d      = out_data;
        @(posedge clk);
        #1;
        if (popped) got_q.push_back(d);
    endtask

    initial begin
        logic [DW-1:0] exp_q[$];
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b0;
        en        = 1'b0;
        a0_in     = '0;
        clr_ovf   = 1'b0;
        out_ready = 1'b0;
        en2       = 1'b0;
        a0_2      = '0;
        clr2      = 1'b0;
        ready2    = 1'b0;

        // Reset state
        #22;
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drops", drop_count, 0);
        check("rst_data", out_data, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: constant 0 with en=1 -> exactly one entry
        en    = 1'b1;
        a0_in = 0;
        check("t1_valid_pre", out_valid, 0);
        cycle();
        check("t1_valid_first", out_valid, 1);
        check("t1_data_first", out_data, 0);
        check("t1_level_first", level, 1);
        repeat (4) cycle();
        check("t1_level_5", level, 1);
        check("t1_data_5", out_data, 0);

        // 2: duplicate suppression while draining
        out_ready = 1'b1;
        got_q.delete();
        foreach (exp_q[i]) exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: a0_in = 1;
                1: a0_in = 2;
                2: a0_in = 2;
                3: a0_in = 3;
                4: a0_in = 3;
                5: a0_in = 3;
                default: a0_in = 5;
            endcase
            cycle();
            check("t2_level_le1", level <= 1, 1);
        end
        exp_q = '{0, 1, 2, 3, 5};
        check("t2_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) check($sformatf("t2_pop%0d", i), got_q[i], exp_q[i]);
        end
        check("t2_empty", out_valid, 0);

        // Small instance: 6 changing samples into DEPTH=2 -> 4 drops, saturates at 3
        en2 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            a0_2 = i;
            cycle();
        end
        en2 = 1'b0;
        check("sat_level", level2, 2);
        check("sat_full", full2, 1);
        check("sat_ovf", overflow2, 1);
        check("sat_drops", drop_count2, 3);
        check("sat_head", out_data2, 1);

        // 3: fill and overflow
        out_ready = 1'b0;
        got_q.delete();
        for (int i = 1; i <= 20; i++) begin
            a0_in = i;
            cycle();
            if (i == 16) check("t3_full_at16", full, 1);
            if (i == 15) check("t3_notfull_at15", full, 0);
        end
        check("t3_level", level, 16);
        check("t3_ovf", overflow, 1);
        check("t3_drops", drop_count, 4);
        check("t3_head", out_data, 1);

        // 4: push into full FIFO with a same-cycle pop is accepted
        a0_in     = 99;
        out_ready = 1'b1;
        cycle();
        check("t4_level", level, 16);
        check("t4_drops", drop_count, 4);
        check("t4_head", out_data, 2);
        // clear coincident with a drop: drop wins, count restarts at 1
        a0_in     = 100;
        out_ready = 1'b0;
        clr_ovf   = 1'b1;
        cycle();
        check("t4_clrdrop_cnt", drop_count, 1);
        check("t4_clrdrop_ovf", overflow, 1);
        // plain clear
        cycle();
        clr_ovf = 1'b0;
        check("t4_clr_cnt", drop_count, 0);
        check("t4_clr_ovf", overflow, 0);
        // drain with capture disabled
        en        = 1'b0;
        out_ready = 1'b1;
        repeat (16) cycle();
        exp_q.delete();
        for (int v = 1; v <= 16; v++) exp_q.push_back(v);
        exp_q.push_back(99);
        check("t34_count", got_q.size(), 17);
        for (int i = 0; i < 17; i++) begin
            if (i < got_q.size()) check($sformatf("t34_pop%0d", i), got_q[i], exp_q[i]);
        end
        check("t4_level_end", level, 0);
        check("t4_valid_end", out_valid, 0);

        // 5: changes while disabled are ignored
        out_ready = 1'b0;
        a0_in = 7; cycle();
        a0_in = 8; cycle();
        a0_in = 9; cycle();
        check("t5_level_dis", level, 0);
        en = 1'b1;
        cycle();
        check("t5_level", level, 1);
        check("t5_data", out_data, 9);
        cycle();
        check("t5_level_hold", level, 1);

        // 6: fill to 10 then asynchronous reset mid-cycle
        for (int i = 10; i <= 18; i++) begin
            a0_in = i;
            cycle();
        end
        check("t6_level10", level, 10);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_full", full, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_ovf2", overflow2, 0);
        check("t6_rst_drops2", drop_count2, 0);
        a0_in = 0;
        #1;
        rst = 1'b1;
        cycle();
        check("t6_post_valid", out_valid, 1);
        check("t6_post_level", level, 1);
        check("t6_post_data", out_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/a0_trace_fifo.md
Name: a0_trace_fifo

Overview:
- Downstream consumer of the CPU top-level `a0` result output.
- Samples `a0` every enabled cycle and detects value changes.
- Pushes each new value into a FIFO, drained by a host/testbench over a valid/ready interface.
- Counts values lost to overflow, so program output sequences (e.g. counter or PDF results) are captured losslessly or flagged.

Parameters:
- DATA_WIDTH, 32, width of the sampled `a0` value and FIFO entries.
- DEPTH, 16, FIFO entries; must be a power of two ≥ 2.
- CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- en  input  1  capture enable; when 0, `a0_in` is ignored.
- a0_in  input  DATA_WIDTH  `a0` value from the CPU top.
- clr_ovf  input  1  synchronous clear of `overflow` and `drop_count`.
- out_data  output  DATA_WIDTH  FIFO head value; valid when `out_valid` = 1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head this cycle.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky: at least one push dropped.
- drop_count  output  CNT_WIDTH  number of dropped pushes, saturating.

Behaviour:

Reset (rst = 0, asynchronous assert, synchronous deassert by the system):
- All outputs 0: `out_data`=0, `out_valid`=0, `level`=0, `full`=0, `overflow`=0, `drop_count`=0.
- Read/write pointers = 0; internal `prev_a0` = 0; internal `first` flag = 1.
- Reset mid-stream discards all FIFO contents and counts.

Change detection (per rising edge, en = 1):
- push_req = `first` OR (`a0_in` != `prev_a0`).
- `prev_a0` <= `a0_in`; `first` <= 0.

When en = 0:
- push_req = 0.
- `prev_a0` and `first` hold.

FIFO:
- Circular buffer of DEPTH entries.
- Pointers are $clog2(DEPTH)+1 bits; wrap naturally, MSB distinguishes full from empty.
- pop = `out_valid` AND `out_ready`.
- Show-ahead: `out_data` always presents the head entry; no read latency.
- Latency: `a0_in` change sampled at edge N gives `out_valid` = 1 and `out_data` = value after edge N (visible cycle N+1).

Push/pop cases:
- push_req, not full: write at wptr, wptr+1.
- push_req, full, pop same cycle: push accepted; level unchanged; no drop.
- push_req, full, no pop: value dropped; `overflow` <= 1; `drop_count` <= `drop_count` + 1, saturating at 2^CNT_WIDTH−1.
- pop with empty FIFO: impossible (`out_valid` = 0); `out_ready` ignored.
- Simultaneous push and pop, not full: level unchanged; both pointers advance.
- `level` = wptr − rptr; `full` and `out_valid` derive from registered pointers only.

clr_ovf:
- clr_ovf = 1: `overflow` <= 0, `drop_count` <= 0.
- If a drop occurs in the same cycle, the drop wins: `overflow` <= 1, `drop_count` <= 1.

Other rules:
- `out_data` content is don't-care when `out_valid` = 0. The bench must not check it; RTL may return a stale entry.
- No combinational path from `out_ready` to `out_valid`.

Test Plan:
1. Reset then en=1 with `a0_in` held at 0 for 5 cycles -> exactly one entry (0). `level`=1, `out_data`=0, `out_valid` rises the cycle after the first enabled edge.
2. `a0_in` = 1, 2, 2, 3, 3, 3, 5, one per cycle, `out_ready`=1 -> drained sequence 0(first), 1, 2, 3, 5. No duplicates; `level` never exceeds 1.
3. `out_ready`=0, `a0_in` incrementing 1..20 each cycle, DEPTH=16 -> `full`=1 after 16 pushes. Remaining 4 dropped: `overflow`=1, `drop_count`=4; drain yields 1..16 in order.
4. FIFO full, `out_ready`=1 and new value 99 in the same cycle -> 99 accepted, `level` stays 16, `drop_count` unchanged. Later `clr_ovf`=1 coincident with a drop -> `drop_count`=1, `overflow`=1.
5. en=0 while `a0_in` changes 7 -> 8 -> 9, then en=1 with `a0_in`=9 -> single push of 9 only.
6. Assert rst low asynchronously mid-cycle with `level`=10 -> all outputs 0 immediately. After release, the first enabled sample is pushed even if equal to 0.
